// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared types for the bit-per-pixel frame-buffer writer.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

    typedef enum logic [1:0] {
        OP_SET    = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_TOGGLE = 2'd2,
        OP_FILL   = 2'd3
    } fb_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4,
        ST_FILL = 3'd5
    } fb_state_t;

    // New value of a single pixel after a SET/CLEAR/TOGGLE
    function automatic logic fb_apply_op(input fb_op_t op, input logic cur);
        logic res;
        res = cur;
        case (op)
            OP_SET:    res = 1'b1;
            OP_CLEAR:  res = 1'b0;
            OP_TOGGLE: res = ~cur;
            default:   res = cur;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_addr_map.sv
`default_nettype none
// ============================================================================
//  Module      : fb_addr_map
//  Description : Maps a pixel (x,y) to RAM word address, bit index (MSB is the
//                leftmost pixel) and an in-range flag. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_addr_map
    import fb_pkg::*;
#(
    parameter int RAM_WIDTH  = 16,
    parameter int GRID_COLS  = 32,
    parameter int GRID_ROWS  = 24,
    parameter int ADDR_WIDTH = 6,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 5,
    parameter int BIT_WIDTH  = 4
) (
    input  logic [X_WIDTH-1:0]    x,
    input  logic [Y_WIDTH-1:0]    y,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic [BIT_WIDTH-1:0]  bit_idx,
    output logic                  in_range
);

    localparam int WORDS_PER_ROW = GRID_COLS / RAM_WIDTH;

    always_comb begin
        word_addr = ADDR_WIDTH'(32'(y) * WORDS_PER_ROW + 32'(x) / RAM_WIDTH);
        bit_idx   = BIT_WIDTH'(RAM_WIDTH - 1 - (32'(x) % RAM_WIDTH));
        in_range  = (32'(x) < GRID_COLS) && (32'(y) < GRID_ROWS);
    end

endmodule
`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pixel_writer
//  Description : Write side of the bit-per-pixel display RAM. Pixel commands
//                are read-modify-write of one word; FILL (only when
//                FB_WRITER_FILL_EN is defined) streams the whole RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int  RAM_WIDTH     = 16,
    parameter int  GRID_COLS     = 32,
    parameter int  GRID_ROWS     = 24,
    parameter int  RAM_LATENCY   = 1,
    localparam int WORDS_PER_ROW = GRID_COLS / RAM_WIDTH,
    localparam int NUM_WORDS     = WORDS_PER_ROW * GRID_ROWS,
    localparam int ADDR_WIDTH    = $clog2(NUM_WORDS),
    localparam int X_WIDTH       = $clog2(GRID_COLS),
    localparam int Y_WIDTH       = $clog2(GRID_ROWS),
    localparam int BIT_WIDTH     = (RAM_WIDTH > 1) ? $clog2(RAM_WIDTH) : 1
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [X_WIDTH-1:0]    cmd_x,
    input  logic [Y_WIDTH-1:0]    cmd_y,
    input  logic                  cmd_fill,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd_en,
    input  logic [RAM_WIDTH-1:0]  ram_rd_data,
    output logic                  ram_wr_en,
    output logic [RAM_WIDTH-1:0]  ram_wr_data,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    fb_state_t             r_state, w_nxt_state;
    fb_op_t                r_op, w_nxt_op;
    logic [BIT_WIDTH-1:0]  r_bit, w_nxt_bit;
    logic [1:0]            r_wait, w_nxt_wait;
    logic                  r_ready, w_nxt_ready;
    logic                  r_rd_en, w_nxt_rd_en;
    logic                  r_wr_en, w_nxt_wr_en;
    logic                  r_done, w_nxt_done;
    logic                  r_err, w_nxt_err;
    logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
    logic [RAM_WIDTH-1:0]  r_wr_data, w_nxt_wr_data;
    logic [RAM_WIDTH-1:0]  w_mod_word;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [BIT_WIDTH-1:0]  w_bit_idx;
    logic                  w_in_range;

    fb_addr_map #(
        .RAM_WIDTH  (RAM_WIDTH),
        .GRID_COLS  (GRID_COLS),
        .GRID_ROWS  (GRID_ROWS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH),
        .BIT_WIDTH  (BIT_WIDTH)
    ) u_addr_map (
        .x          (cmd_x),
        .y          (cmd_y),
        .word_addr  (w_word_addr),
        .bit_idx    (w_bit_idx),
        .in_range   (w_in_range)
    );

`ifndef FB_WRITER_FILL_EN
    logic w_unused_fill;
    assign w_unused_fill = cmd_fill;
`endif

    always_comb begin
        w_mod_word        = ram_rd_data;
        w_mod_word[r_bit] = fb_apply_op(r_op, ram_rd_data[r_bit]);
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_op      = r_op;
        w_nxt_bit     = r_bit;
        w_nxt_wait    = r_wait;
        w_nxt_ready   = r_ready;
        w_nxt_rd_en   = 1'b0;
        w_nxt_wr_en   = 1'b0;
        w_nxt_done    = 1'b0;
        w_nxt_err     = 1'b0;
        w_nxt_addr    = r_addr;
        w_nxt_wr_data = r_wr_data;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_nxt_op  = fb_op_t'(cmd_op);
                    w_nxt_bit = w_bit_idx;
                    if (fb_op_t'(cmd_op) == OP_FILL) begin
`ifdef FB_WRITER_FILL_EN
                        w_nxt_state   = ST_FILL;
                        w_nxt_ready   = 1'b0;
                        w_nxt_wr_en   = 1'b1;
                        w_nxt_addr    = '0;
                        w_nxt_wr_data = {RAM_WIDTH{cmd_fill}};
                        w_nxt_done    = (NUM_WORDS == 1);
`else
                        w_nxt_err     = 1'b1;
`endif
                    end else if (!w_in_range) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_nxt_state = ST_RD;
                        w_nxt_ready = 1'b0;
                        w_nxt_rd_en = 1'b1;
                        w_nxt_addr  = w_word_addr;
                    end
                end
            end
            ST_RD: begin
                if (RAM_LATENCY == 1) begin
                    w_nxt_state = ST_CAP;
                end else begin
                    w_nxt_state = ST_WAIT;
                    w_nxt_wait  = 2'(RAM_LATENCY - 2);
                end
            end
            ST_WAIT: begin
                if (r_wait == 2'd0) begin
                    w_nxt_state = ST_CAP;
                end else begin
                    w_nxt_wait = r_wait - 2'd1;
                end
            end
            ST_CAP: begin
                w_nxt_state   = ST_WR;
                w_nxt_wr_en   = 1'b1;
                w_nxt_done    = 1'b1;
                w_nxt_wr_data = w_mod_word;
            end
            ST_WR: begin
                w_nxt_state = ST_IDLE;
                w_nxt_ready = 1'b1;
            end
`ifdef FB_WRITER_FILL_EN
            ST_FILL: begin
                // Counter saturates at the last word; never wraps back to 0
                if (r_addr == C_LAST_ADDR) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_ready = 1'b1;
                end else begin
                    w_nxt_addr  = r_addr + ADDR_WIDTH'(1);
                    w_nxt_wr_en = 1'b1;
                    w_nxt_done  = (r_addr + ADDR_WIDTH'(1) == C_LAST_ADDR);
                end
            end
`endif
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_SET;
            r_bit     <= '0;
            r_wait    <= 2'd0;
            r_ready   <= 1'b1;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_op      <= w_nxt_op;
            r_bit     <= w_nxt_bit;
            r_wait    <= w_nxt_wait;
            r_ready   <= w_nxt_ready;
            r_rd_en   <= w_nxt_rd_en;
            r_wr_en   <= w_nxt_wr_en;
            r_done    <= w_nxt_done;
            r_err     <= w_nxt_err;
            r_addr    <= w_nxt_addr;
            r_wr_data <= w_nxt_wr_data;
        end
    end

    assign cmd_ready   = r_ready;
    assign ram_addr    = r_addr;
    assign ram_rd_en   = r_rd_en;
    assign ram_wr_en   = r_wr_en;
    assign ram_wr_data = r_wr_data;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_pixel_writer
//  Description : Self-checking bench for fb_pixel_writer against a pixel-grid
//                reference model and a RAM model with configurable latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_pixel_writer;

    localparam int RW  = 16;
    localparam int GC  = 32;
    localparam int GR  = 24;
    localparam int LAT = 3;
    localparam int WPR = GC / RW;
    localparam int NW  = WPR * GR;
    localparam int AW  = $clog2(NW);

    logic          CLK_50 = 1'b0;
    logic          RESET  = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [4:0]    cmd_x = 5'd0;
    logic [4:0]    cmd_y = 5'd0;
    logic          cmd_fill = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_rd_en;
    logic [RW-1:0] ram_rd_data;
    logic          ram_wr_en;
    logic [RW-1:0] ram_wr_data;
    logic          done;
    logic          err;

    fb_pixel_writer #(
        .RAM_WIDTH   (RW),
        .GRID_COLS   (GC),
        .GRID_ROWS   (GR),
        .RAM_LATENCY (LAT)
    ) dut (
        .CLK_50      (CLK_50),
        .RESET       (RESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_fill    (cmd_fill),
        .ram_addr    (ram_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_data (ram_wr_data),
        .done        (done),
        .err         (err)
    );

    always #10 CLK_50 = ~CLK_50;

    // RAM model with backdoor load and LAT-cycle read pipeline
    logic [RW-1:0] mem [NW];
    logic [RW-1:0] rd_pipe [LAT];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [RW-1:0] bd_data = '0;
    int            rd_cnt = 0, wr_cnt = 0, ovl_cnt = 0, bad_cnt = 0;

    always @(posedge CLK_50) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (ram_wr_en && int'(ram_addr) < NW)
            mem[ram_addr] <= ram_wr_data;
        if (ram_wr_en) wr_cnt <= wr_cnt + 1;
        if (ram_rd_en) rd_cnt <= rd_cnt + 1;
        if (ram_rd_en && ram_wr_en) ovl_cnt <= ovl_cnt + 1;
        if ((ram_wr_en || ram_rd_en) && int'(ram_addr) >= NW) bad_cnt <= bad_cnt + 1;
        rd_pipe[0] <= (ram_rd_en && int'(ram_addr) < NW) ? mem[ram_addr] : 16'hDEAD;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[LAT-1];

    // Reference: the picture itself, one bit per pixel
    bit pix [GR][GC];
    int n_vec = 0, n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] ref_word(input int a);
        logic [RW-1:0] w;
        int row, col0;
        row  = a / WPR;
        col0 = (a % WPR) * RW;
        for (int b = 0; b < RW; b++) w[RW-1-b] = pix[row][col0+b];
        return w;
    endfunction

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int a = 0; a < NW; a++) if (mem[a] !== ref_word(a)) n++;
        return n;
    endfunction

    task automatic run_cmd(input int op, input int x, input int y, input bit fill);
        int kind, win, done_at, err_at, done_n, err_n, rd0, wr0, a;
        logic [AW-1:0] done_addr;
        logic rdy_end, rdy_pre;
        bit inr;
        inr = (x < GC) && (y < GR);
        if (op == 3) begin
`ifdef FB_WRITER_FILL_EN
            kind = 2;
`else
            kind = 0;
`endif
        end else begin
            kind = inr ? 1 : 0;
        end
        win = (kind == 0) ? 1 : (kind == 1) ? LAT + 3 : NW + 1;
        @(negedge CLK_50);
        chk_val("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_x = 5'(x); cmd_y = 5'(y); cmd_fill = fill;
        rd0 = rd_cnt; wr0 = wr_cnt;
        done_at = -1; err_at = -1; done_n = 0; err_n = 0;
        done_addr = '0; rdy_end = 1'b0; rdy_pre = 1'b0;
        for (int c = 1; c <= win + 1; c++) begin
            @(negedge CLK_50);
            if (c == 1) cmd_valid = 1'b0;
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) begin done_at = c; done_addr = ram_addr; end
            end
            if (err === 1'b1) begin
                err_n++;
                if (err_at < 0) err_at = c;
            end
            if (c == win - 1) rdy_pre = cmd_ready;
            if (c == win) rdy_end = cmd_ready;
        end
        if (kind == 0) begin
            chk_val("err_cnt", err_n, 1);
            chk_val("err_lat", err_at, 1);
            chk_val("err_done", done_n, 0);
            chk_val("err_rd", rd_cnt - rd0, 0);
            chk_val("err_wr", wr_cnt - wr0, 0);
            chk_val("err_ready", rdy_end, 1);
        end else if (kind == 1) begin
            chk_val("pix_done_cnt", done_n, 1);
            chk_val("pix_done_lat", done_at, LAT + 2);
            chk_val("pix_err", err_n, 0);
            chk_val("pix_rd", rd_cnt - rd0, 1);
            chk_val("pix_wr", wr_cnt - wr0, 1);
            chk_val("pix_busy", rdy_pre, 0);
            chk_val("pix_ready", rdy_end, 1);
            case (op)
                0: pix[y][x] = 1'b1;
                1: pix[y][x] = 1'b0;
                default: pix[y][x] = ~pix[y][x];
            endcase
            a = y * WPR + x / RW;
            chk_val("pix_word", mem[a], ref_word(a));
        end else begin
            chk_val("fill_done_cnt", done_n, 1);
            chk_val("fill_done_lat", done_at, NW);
            chk_val("fill_done_addr", done_addr, NW - 1);
            chk_val("fill_err", err_n, 0);
            chk_val("fill_rd", rd_cnt - rd0, 0);
            chk_val("fill_wr", wr_cnt - wr0, NW);
            chk_val("fill_busy", rdy_pre, 0);
            chk_val("fill_ready", rdy_end, 1);
            for (int r = 0; r < GR; r++)
                for (int c = 0; c < GC; c++) pix[r][c] = fill;
        end
        chk_val("mem_image", mem_diff(), 0);
    endtask

    initial begin
        int wr0, op;
        for (int r = 0; r < GR; r++)
            for (int c = 0; c < GC; c++) pix[r][c] = bit'($urandom_range(0, 1));
        for (int c = 16; c < 32; c++) pix[0][c] = 1'b0;
        for (int c = 0; c < 16; c++) pix[23][c] = 1'b1;
        for (int c = 0; c < 16; c++) pix[1][c] = (c == 15);

        for (int a = 0; a < NW; a++) begin
            @(negedge CLK_50);
            bd_we = 1'b1; bd_addr = AW'(a); bd_data = ref_word(a);
        end
        @(negedge CLK_50);
        bd_we = 1'b0;
        chk_val("rst_ready", cmd_ready, 1);
        chk_val("rst_rd_en", ram_rd_en, 0);
        chk_val("rst_wr_en", ram_wr_en, 0);
        chk_val("rst_done", done, 0);
        chk_val("rst_err", err, 0);
        chk_val("rst_addr", ram_addr, 0);
        chk_val("rst_wr_data", ram_wr_data, 0);
        RESET = 1'b0;

        run_cmd(0, 17, 0, 1'b0);
        chk_val("t1_word1", mem[1], 16'h4000);
        run_cmd(1, 0, 23, 1'b0);
        chk_val("t2_word46", mem[46], 16'h7FFF);
        run_cmd(2, 15, 1, 1'b0);
        chk_val("t3_word2_a", mem[2], 16'h0000);
        run_cmd(2, 15, 1, 1'b0);
        chk_val("t3_word2_b", mem[2], 16'h0001);
        run_cmd(0, 5, 24, 1'b0);
        run_cmd(2, 31, 31, 1'b0);
        run_cmd(3, 0, 0, 1'b1);

        // Reset while waiting for read data must abort without a write
        @(negedge CLK_50);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_x = 5'd3; cmd_y = 5'd7;
        @(negedge CLK_50);
        cmd_valid = 1'b0;
        @(negedge CLK_50);
        wr0 = wr_cnt;
        RESET = 1'b1;
        #1;
        chk_val("arst_ready", cmd_ready, 1);
        chk_val("arst_wr_en", ram_wr_en, 0);
        chk_val("arst_rd_en", ram_rd_en, 0);
        repeat (2) @(negedge CLK_50);
        RESET = 1'b0;
        chk_val("arst_ready_post", cmd_ready, 1);
        repeat (LAT + 4) @(negedge CLK_50);
        chk_val("arst_no_wr", wr_cnt - wr0, 0);
        chk_val("arst_mem", mem_diff(), 0);
        run_cmd(0, 3, 7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            if (op == 3 && $urandom_range(0, 3) != 0) op = int'($urandom_range(0, 2));
            run_cmd(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 27)),
                    bit'($urandom_range(0, 1)));
        end

        chk_val("rd_wr_overlap", ovl_cnt, 0);
        chk_val("addr_beyond_end", bad_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
